// File: rtl/lgn_pkg.sv
// Shared types and width helpers for the logic-gate-net scoring back-end.
package lgn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_REDUCE
  } state_t;

  // Width needed to hold any count from 0 to bits inclusive; never below 1.
  function automatic int sum_width(input int bits);
    return (bits < 1) ? 1 : $clog2(bits + 1);
  endfunction

  // Index width for cats entries; a single category still gets one bit.
  function automatic int idx_width(input int cats);
    return (cats <= 1) ? 1 : $clog2(cats);
  endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Purely combinational population count of an N-bit slice.
module chunk_popcount #(
  parameter  int N = 40,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  // Ripple sum of the individual bits; synthesis folds this into an adder tree.
  always_comb begin
    count = '0;
    for (int b = 0; b < N; b++) begin
      count = count + W'(bits[b]);
    end
  end

endmodule

// File: rtl/lgn_argmax_seq.sv
// Sequential popcount + argmax scorer for the logic-gate network outputs.
// Counts every category CHUNK bits per cycle, then scans one category per
// cycle for the best score, the runner-up and the tie condition.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; results from the last run are held
//   S_COUNT  | accumulating chunk k of every category (NCHUNK cycles)
//   S_REDUCE | scanning category j for best/second (CATEGORIES cycles)
module lgn_argmax_seq
  import lgn_pkg::*;
#(
  parameter  int CATEGORIES        = 10,
  parameter  int BITS_PER_CATEGORY = 800,
  parameter  int CHUNK             = 40,
  localparam int SUM_W             = sum_width(BITS_PER_CATEGORY),
  localparam int IDX_W             = idx_width(CATEGORIES)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] y_categories,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    valid,
  output logic [IDX_W-1:0]                        best_index,
  output logic [SUM_W-1:0]                        best_value,
  output logic [SUM_W-1:0]                        margin,
  output logic                                    tie
);

  localparam int NCHUNK = BITS_PER_CATEGORY / CHUNK;
  localparam int PC_W   = $clog2(CHUNK + 1);
  localparam int K_W    = (NCHUNK <= 1) ? 1 : $clog2(NCHUNK);
  localparam logic [K_W-1:0]   K_LAST = K_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(CATEGORIES - 1);

  if (BITS_PER_CATEGORY % CHUNK != 0) begin : g_bad_chunk
    $error("lgn_argmax_seq: CHUNK must divide BITS_PER_CATEGORY");
  end
  if (CATEGORIES < 1) begin : g_bad_categories
    $error("lgn_argmax_seq: CATEGORIES must be at least 1");
  end

  state_t           state;
  logic [K_W-1:0]   k;
  logic [IDX_W-1:0] j;
  logic [SUM_W-1:0] acc [CATEGORIES];
  logic [PC_W-1:0]  pc  [CATEGORIES];

  logic [SUM_W-1:0] run_best;
  logic [SUM_W-1:0] run_second;
  logic [IDX_W-1:0] run_idx;

  logic [SUM_W-1:0] cur;
  logic [SUM_W-1:0] nxt_best;
  logic [SUM_W-1:0] nxt_second;
  logic [IDX_W-1:0] nxt_idx;

  for (genvar i = 0; i < CATEGORIES; i++) begin : g_pc
    chunk_popcount #(.N(CHUNK)) u_pc (
      .bits  (y_categories[i*BITS_PER_CATEGORY + k*CHUNK +: CHUNK]),
      .count (pc[i])
    );
  end

  // One step of the running argmax; strict compares keep the lowest index on ties.
  always_comb begin
    cur        = acc[j];
    nxt_best   = run_best;
    nxt_second = run_second;
    nxt_idx    = run_idx;
    if (cur > run_best) begin
      nxt_second = run_best;
      nxt_best   = cur;
      nxt_idx    = j;
    end else if (cur > run_second) begin
      nxt_second = cur;
    end
  end

  // Sequencer: accept, count chunks, reduce, publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      j          <= '0;
      run_best   <= '0;
      run_second <= '0;
      run_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      best_index <= '0;
      best_value <= '0;
      margin     <= '0;
      tie        <= 1'b0;
      for (int i = 0; i < CATEGORIES; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < CATEGORIES; i++) acc[i] <= '0;
            k     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            valid <= 1'b0;
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < CATEGORIES; i++) acc[i] <= acc[i] + SUM_W'(pc[i]);
          k <= k + 1'b1;
          if (k == K_LAST) begin
            k          <= '0;
            j          <= '0;
            run_best   <= '0;
            run_second <= '0;
            run_idx    <= '0;
            state      <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          run_best   <= nxt_best;
          run_second <= nxt_second;
          run_idx    <= nxt_idx;
          j          <= j + 1'b1;
          if (j == J_LAST) begin
            best_index <= nxt_idx;
            best_value <= nxt_best;
            margin     <= nxt_best - nxt_second;
            tie        <= (nxt_best == nxt_second) && (CATEGORIES > 1);
            done       <= 1'b1;
            valid      <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lgn_argmax_seq.sv
// Randomised and directed bench for lgn_argmax_seq with a run-level score model.
module tb_lgn_argmax_seq;

  localparam int CAT     = 10;
  localparam int BPC     = 800;
  localparam int CH      = 40;
  localparam int NCH     = BPC / CH;
  localparam int SW      = 10;
  localparam int IW      = 4;
  localparam int RUN_LAT = NCH + CAT;

  logic clk = 1'b0;
  logic rst, start, start1;
  logic [CAT*BPC-1:0] vec;
  logic [7:0] vec1;

  logic busy, done, valid, tie;
  logic [IW-1:0] best_index;
  logic [SW-1:0] best_value, margin;

  logic busy1, done1, valid1, tie1;
  logic [0:0] best_index1;
  logic [3:0] best_value1, margin1;

  always #5 clk = ~clk;

  lgn_argmax_seq dut (
    .clk(clk), .rst(rst), .start(start), .y_categories(vec),
    .busy(busy), .done(done), .valid(valid), .best_index(best_index),
    .best_value(best_value), .margin(margin), .tie(tie)
  );

  lgn_argmax_seq #(.CATEGORIES(1), .BITS_PER_CATEGORY(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_categories(vec1),
    .busy(busy1), .done(done1), .valid(valid1), .best_index(best_index1),
    .best_value(best_value1), .margin(margin1), .tie(tie1)
  );

  int tests  = 0;
  int failed = 0;
  bit check_en = 1'b0;

  // Run-level model: a run accepted in idle publishes its scores RUN_LAT edges later.
  int   m_cnt = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, m_tie = 1'b0;
  int   m_idx = 0, m_val = 0, m_mar = 0;
  int   p_idx, p_val, p_mar;
  logic p_tie;

  function automatic void score(input logic [CAT*BPC-1:0] v, output int idx,
                                output int val, output int mar, output logic t);
    int s [CAT];
    int best, second;
    best = -1; second = 0; idx = 0;
    for (int i = 0; i < CAT; i++) begin
      s[i] = $countones(v[i*BPC +: BPC]);
      if (s[i] > best) begin best = s[i]; idx = i; end
    end
    for (int i = 0; i < CAT; i++)
      if (i != idx && s[i] > second) second = s[i];
    val = best;
    mar = best - second;
    t   = (CAT > 1) && (mar == 0);
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_cnt = 0; m_busy = 0; m_valid = 0; m_tie = 0;
      m_idx = 0; m_val = 0; m_mar = 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt = RUN_LAT; m_busy = 1; m_valid = 0;
        score(vec, p_idx, p_val, p_mar, p_tie);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_done = 1; m_valid = 1;
        m_idx = p_idx; m_val = p_val; m_mar = p_mar; m_tie = p_tie;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if (busy !== m_busy || done !== m_done || valid !== m_valid || tie !== m_tie ||
          best_index !== IW'(m_idx) || best_value !== SW'(m_val) || margin !== SW'(m_mar)) begin
        failed++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b valid=%b idx=%0d val=%0d mar=%0d tie=%b want busy=%b done=%b valid=%b idx=%0d val=%0d mar=%0d tie=%b",
                 $time, busy, done, valid, best_index, best_value, margin, tie,
                 m_busy, m_done, m_valid, m_idx, m_val, m_mar, m_tie);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // Sets `lo` ones at the bottom and `hi` ones at the top of category c.
  task automatic fill(input int c, input int lo, input int hi);
    for (int b = 0; b < BPC; b++) vec[c*BPC + b] = (b < lo) || (b >= BPC - hi);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < CAT; i++) begin
      int mode;
      mode = $urandom_range(0, 4);
      for (int w = 0; w < BPC/32; w++) begin
        case (mode)
          0: vec[i*BPC + w*32 +: 32] = $urandom;
          1: vec[i*BPC + w*32 +: 32] = $urandom & $urandom & $urandom;
          2: vec[i*BPC + w*32 +: 32] = vec[w*32 +: 32];
          3: vec[i*BPC + w*32 +: 32] = '0;
          default: vec[i*BPC + w*32 +: 32] = $urandom | $urandom;
        endcase
      end
    end
  endtask

  // Pulses start while idle and returns edges from accept to done.
  task automatic run_one(input string nm, output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 200);
    if (!done) begin
      tests++; failed++;
      $display("FAIL %s_timeout got no done want done within 200 cycles", nm);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_cnt != 0 && n < 200) begin @(negedge clk); n++; end
    if (m_cnt != 0) begin
      tests++; failed++;
      $display("FAIL idle_timeout got busy want idle");
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
  endtask

  initial begin
    #2000000;
    tests++; failed++;
    $display("FAIL watchdog got running want finished");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, last, ndone, c;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; vec = '0; vec1 = '0;
    repeat (3) @(posedge clk);
    #1; check_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_value", int'(best_value), 0);
    chk("rst_value1", int'(best_value1), 0);
    @(negedge clk); rst = 1'b0;

    // All zero: lowest index wins with a zero-margin tie.
    vec = '0;
    run_one("zero", lat);
    chk("zero_lat", lat, 30);
    chk("zero_idx", int'(best_index), 0);
    chk("zero_val", int'(best_value), 0);
    chk("zero_mar", int'(margin), 0);
    chk("zero_tie", int'(tie), 1);

    vec = '0; fill(7, BPC, 0);
    run_one("cat7", lat);
    chk("cat7_idx", int'(best_index), 7);
    chk("cat7_val", int'(best_value), 800);
    chk("cat7_mar", int'(margin), 800);
    chk("cat7_tie", int'(tie), 0);

    for (int i = 0; i < CAT; i++) fill(i, 50, 50);
    fill(3, 250, 250); fill(8, 250, 250);
    run_one("tie38", lat);
    chk("tie38_idx", int'(best_index), 3);
    chk("tie38_val", int'(best_value), 500);
    chk("tie38_mar", int'(margin), 0);
    chk("tie38_tie", int'(tie), 1);

    for (int i = 0; i < CAT; i++) fill(i, 50*i, 0);
    run_one("ramp", lat);
    chk("ramp_idx", int'(best_index), 9);
    chk("ramp_val", int'(best_value), 450);
    chk("ramp_mar", int'(margin), 50);
    chk("ramp_tie", int'(tie), 0);

    repeat (12) begin
      rand_vec();
      run_one("rand", lat);
      chk("rand_lat", lat, 30);
    end

    // start held high: runs back to back every RUN_LAT+1 cycles.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    last = -1; ndone = 0;
    for (c = 1; c <= 130; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (last < 0) chk("held_first", c, 30);
        else chk("held_period", c - last, 31);
        last = c; ndone++;
      end
    end
    chk("held_count", ndone, 4);
    @(negedge clk); start = 1'b0;
    wait_idle();

    // Random start pulses, including while busy; vector changes only when idle.
    repeat (400) begin
      @(negedge clk);
      if (m_cnt == 0) rand_vec();
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    wait_idle();

    // Reset ten cycles into a run aborts it without a done.
    vec = '0; fill(2, 300, 0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_val", int'(best_value), 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort_nodone", ndone, 0);
    run_one("after_abort", lat);
    chk("after_abort_lat", lat, 30);
    chk("after_abort_idx", int'(best_index), 2);
    chk("after_abort_val", int'(best_value), 300);

    // Single-category instance.
    vec1 = 8'hFF;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done1 && lat < 50);
    chk("one_lat", lat, 2);
    chk("one_idx", int'(best_index1), 0);
    chk("one_val", int'(best_value1), 8);
    chk("one_mar", int'(margin1), 8);
    chk("one_tie", int'(tie1), 0);

    repeat (3) @(posedge clk);
    summary();
    $finish;
  end

endmodule

// File: doc/lgn_argmax_seq.md
# lgn_argmax_seq

Sequential, parametrised scoring back-end for the logic-gate network. It takes the flat per-category output bit vector of the net, popcounts each category in `CHUNK`-bit slices over several cycles, and runs a one-category-per-cycle argmax. It reports the winning index, its score, the margin to the runner-up and a tie flag through a start/done handshake. It replaces the fully combinational popcount-and-argmax tree between the net and the display/output logic, trading latency for area.

## Interface

Parameters:
- `CATEGORIES`, 10, number of classes; must be ≥1.
- `BITS_PER_CATEGORY`, 800, net output bits per class.
- `CHUNK`, 40, bits popcounted per category per cycle; must divide `BITS_PER_CATEGORY`.
- Derived values:
  - `NCHUNK` = `BITS_PER_CATEGORY/CHUNK`
  - `SUM_W` = `$clog2(BITS_PER_CATEGORY+1)`
  - `IDX_W` = max(1, `$clog2(CATEGORIES)`)

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a scoring run; sampled only in IDLE.
- `y_categories` in `CATEGORIES*BITS_PER_CATEGORY`: category i occupies `[i*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]`. Must be held stable while `busy`=1.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse; results updated this cycle.
- `valid` out 1: result registers hold a completed run.
- `best_index` out `IDX_W`: winning category.
- `best_value` out `SUM_W`: popcount of the winner.
- `margin` out `SUM_W`: best score minus second-best score.
- `tie` out 1: set when another category equals the best score.

## Operation

- FSM states:
  - IDLE → COUNT when `start`=1.
  - COUNT → REDUCE after `NCHUNK` cycles.
  - REDUCE → IDLE after `CATEGORIES` cycles.
- Start accept (IDLE with `start`=1):
  - clear all `CATEGORIES` accumulators, chunk counter k=0 and category counter j=0;
  - set `busy`=1 and `valid`=0.
- COUNT, each cycle:
  - every accumulator i adds the popcount of `y_categories[i*BITS_PER_CATEGORY + k*CHUNK +: CHUNK]`;
  - k increments;
  - after the k=`NCHUNK`-1 cycle, go to REDUCE.
- REDUCE:
  - On entry, running best=0, second=0, idx=0.
  - Each cycle, with a=acc[j]:
    - if a > best: second←best, best←a, idx←j;
    - else if a > second: second←a.
  - The comparison is strict, so on equal scores the lowest index wins.
  - On the j=`CATEGORIES`-1 cycle, register the results:
    - `best_index`←idx and `best_value`←best, both using the final-cycle update;
    - `margin`←best−second;
    - `tie`←(margin==0) && `CATEGORIES`>1;
    - `done`←1, `valid`←1, `busy`←0, state→IDLE.
- Arithmetic:
  - accumulators are `SUM_W` bits and never overflow (max `BITS_PER_CATEGORY`);
  - chunk popcounts are `$clog2(CHUNK+1)` bits, zero-extended before adding.
- `CATEGORIES`=1: `margin`=`best_value`, `tie`=0.
- `start` while `busy`: ignored; no queuing.
- Results hold until the next accepted start.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `valid`=0, `best_index`=0, `best_value`=0, `margin`=0, `tie`=0; accumulators cleared.
- `rst` mid-run aborts immediately: no `done`, and outputs take their reset values on the next edge.
- Latency: with start accepted at edge E0, `done` is high for the cycle after edge E0+`NCHUNK`+`CATEGORIES`. With defaults, that is 30 cycles after the accept edge.
- Throughput: the cycle in which `done`=1 is an IDLE cycle.
  - `start` held high there is accepted, so back-to-back runs occur every `NCHUNK`+`CATEGORIES`+1 cycles (31 with defaults).
  - `valid` drops on that accept edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package `lgn_pkg`:
  - state enum (IDLE, COUNT, REDUCE);
  - `clog2`-safe width helper functions used for `SUM_W` and `IDX_W`.
- Sub-module `chunk_popcount #(N)`:
  - purely combinational popcount of N bits;
  - instantiated `CATEGORIES` times, fed by a k-indexed part-select.
- Elaboration-time checks:
  - `BITS_PER_CATEGORY % CHUNK == 0`;
  - `CATEGORIES ≥ 1`.

## Test plan

All scenarios use default parameters unless stated.
- All-zero vector, start → `done` 30 cycles after accept; `best_index`=0, `best_value`=0, `margin`=0, `tie`=1.
- Category 7 all ones, others zero → `best_index`=7, `best_value`=800, `margin`=800, `tie`=0.
- Categories 3 and 8 at 500 ones, others 100 (ones spread across chunks 0 and 19) → `best_index`=3, `best_value`=500, `margin`=0, `tie`=1.
- Category i holds 50·i ones → `best_index`=9, `best_value`=450, `margin`=50.
- `start` held high continuously, plus extra pulses while `busy` → `done` pulses exactly every 31 cycles; `valid` low from each accept until its `done`.
- `rst` asserted 10 cycles into a run → all outputs zero next cycle and no `done`. A new start then completes normally.
- `CATEGORIES`=1, `BITS_PER_CATEGORY`=8, `CHUNK`=8, input 0xFF → `done` 2 cycles after accept; `best_value`=8, `margin`=8, `tie`=0.
